fsm_control: RTL and testbench

- Main control state machine for the PCIe-lite datapath: one input FIFO and four virtual-channel FIFOs.
- Sequences the datapath through reset, configuration, idle, active and error states.
- Latches the FIFO almost-full/almost-empty thresholds during configuration and distributes them to all five FIFOs.
- Drives the IDLE qualifier used by the word-counter readout block, and records FIFO overflow/underflow errors as sticky flags.

---
 rtl/fsm_pkg.sv | 27 ++
 rtl/umbral_regs.sv | 52 +++++
 rtl/fsm_control.sv | 106 ++++++++++
 tb/tb_fsm_control.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fsm_pkg
//  Purpose  : Shared constants and state encoding for the PCIe-lite control
//             path (control FSM, word counters, FIFOs and checkers).
//  Revision : 1.0 - initial release
// ============================================================================
package fsm_pkg;

   // Bit 4 is the input FIFO, bits 3..0 are VC0..VC3
   localparam int N_FIFO = 5;
   // Threshold width; FIFO depth is 8
   localparam int TH_W   = 3;

   localparam logic [TH_W-1:0] TH_HI_RST = 3'd6;
   localparam logic [TH_W-1:0] TH_LO_RST = 3'd1;

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_INIT   = 3'd1,
      ST_IDLE   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_ERROR  = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/umbral_regs.sv
`default_nettype none
// ============================================================================
//  Module   : umbral_regs
//  Purpose  : Almost-full / almost-empty threshold register pair. Loads the
//             requested thresholds while configuring, unless the request is
//             inconsistent (low >= high), in which case cfg_err is raised and
//             the previous thresholds are kept.
//  Revision : 1.0 - initial release
// ============================================================================
module umbral_regs
   import fsm_pkg::*;
(
   input  logic            CLK,
   input  logic            reset,
   input  logic            in_init,
   input  logic [TH_W-1:0] umbral_alto_in,
   input  logic [TH_W-1:0] umbral_bajo_in,
   output logic [TH_W-1:0] umbral_alto,
   output logic [TH_W-1:0] umbral_bajo,
   output logic            cfg_err
);

   logic [TH_W-1:0] alto_q, alto_d;
   logic [TH_W-1:0] bajo_q, bajo_d;
   logic            cfg_err_w;
   logic            load_w;

   // Validate the request and select the next threshold values
   always_comb begin
      cfg_err_w = in_init && (umbral_bajo_in >= umbral_alto_in);
      load_w    = in_init && !cfg_err_w;
      alto_d    = load_w ? umbral_alto_in : alto_q;
      bajo_d    = load_w ? umbral_bajo_in : bajo_q;
   end

   // Threshold storage, restored to the default pair on reset
   always_ff @(posedge CLK) begin
      if (!reset) begin
         alto_q <= TH_HI_RST;
         bajo_q <= TH_LO_RST;
      end else begin
         alto_q <= alto_d;
         bajo_q <= bajo_d;
      end
   end

   assign umbral_alto = alto_q;
   assign umbral_bajo = bajo_q;
   assign cfg_err     = cfg_err_w;

endmodule
`default_nettype wire

// File: rtl/fsm_control.sv
`default_nettype none
// ============================================================================
//  Module   : fsm_control
//  Purpose  : Main control state machine for the PCIe-lite datapath. Steps
//             through RESET / INIT / IDLE / ACTIVE / ERROR, distributes the
//             FIFO thresholds and keeps sticky per-FIFO error flags.
//  Revision : 1.0 - initial release
// ============================================================================
module fsm_control
   import fsm_pkg::*;
(
   input  logic              CLK,
   input  logic              reset,
   input  logic              init,
   input  logic [TH_W-1:0]   umbral_alto_in,
   input  logic [TH_W-1:0]   umbral_bajo_in,
   input  logic [N_FIFO-1:0] empty,
   input  logic [N_FIFO-1:0] fifo_error,
   output logic [TH_W-1:0]   umbral_alto,
   output logic [TH_W-1:0]   umbral_bajo,
   output logic [2:0]        state,
   output logic              IDLE,
   output logic              active_out,
   output logic [N_FIFO-1:0] error_out,
   output logic              cfg_err
);

   state_t            state_q, state_d;
   logic              idle_q;
   logic              active_q;
   logic [N_FIFO-1:0] error_q, error_d;
   logic              any_err_w;
   logic              all_empty_w;
   logic              in_init_w;

   assign any_err_w   = |fifo_error;
   assign all_empty_w = &empty;
   assign in_init_w   = (state_q == ST_INIT);

   umbral_regs u_umbral_regs (
      .CLK            (CLK),
      .reset          (reset),
      .in_init        (in_init_w),
      .umbral_alto_in (umbral_alto_in),
      .umbral_bajo_in (umbral_bajo_in),
      .umbral_alto    (umbral_alto),
      .umbral_bajo    (umbral_bajo),
      .cfg_err        (cfg_err)
   );

   // Next-state selection (errors win over init) and sticky error accumulation
   always_comb begin
      state_d = state_q;
      error_d = error_q;
      // Errors arriving while still in RESET are deliberately dropped
      if (state_q != ST_RESET) begin
         error_d = error_q | fifo_error;
      end
      case (state_q)
         ST_RESET:  state_d = ST_INIT;
         ST_INIT: begin
            if (any_err_w)      state_d = ST_ERROR;
            else if (init)      state_d = ST_INIT;
            else if (cfg_err)   state_d = ST_INIT;
            else if (all_empty_w) state_d = ST_IDLE;
            else                state_d = ST_ACTIVE;
         end
         ST_IDLE: begin
            if (any_err_w)         state_d = ST_ERROR;
            else if (init)         state_d = ST_INIT;
            else if (!all_empty_w) state_d = ST_ACTIVE;
            else                   state_d = ST_IDLE;
         end
         ST_ACTIVE: begin
            if (any_err_w)        state_d = ST_ERROR;
            else if (init)        state_d = ST_INIT;
            else if (all_empty_w) state_d = ST_IDLE;
            else                  state_d = ST_ACTIVE;
         end
         ST_ERROR:  state_d = ST_ERROR;
         default:   state_d = ST_RESET;
      endcase
   end

   // State register with registered Moore decodes and sticky error flags
   always_ff @(posedge CLK) begin
      if (!reset) begin
         state_q  <= ST_RESET;
         idle_q   <= 1'b0;
         active_q <= 1'b0;
         error_q  <= '0;
      end else begin
         state_q  <= state_d;
         idle_q   <= (state_d == ST_IDLE);
         active_q <= (state_d == ST_ACTIVE);
         error_q  <= error_d;
      end
   end

   assign state      = state_q;
   assign IDLE       = idle_q;
   assign active_out = active_q;
   assign error_out  = error_q;

endmodule
`default_nettype wire

// File: tb/tb_fsm_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fsm_control
//  Purpose  : Self-checking bench for fsm_control: directed vector table for
//             the scenario sequences, then random stimulus against a
//             behavioural reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fsm_control;
   import fsm_pkg::*;

   logic              CLK = 1'b0;
   logic              reset;
   logic              init;
   logic [TH_W-1:0]   umbral_alto_in;
   logic [TH_W-1:0]   umbral_bajo_in;
   logic [N_FIFO-1:0] empty;
   logic [N_FIFO-1:0] fifo_error;
   logic [TH_W-1:0]   umbral_alto;
   logic [TH_W-1:0]   umbral_bajo;
   logic [2:0]        state;
   logic              IDLE;
   logic              active_out;
   logic [N_FIFO-1:0] error_out;
   logic              cfg_err;

   int n_checks = 0;
   int n_pass   = 0;

   fsm_control dut (
      .CLK            (CLK),
      .reset          (reset),
      .init           (init),
      .umbral_alto_in (umbral_alto_in),
      .umbral_bajo_in (umbral_bajo_in),
      .empty          (empty),
      .fifo_error     (fifo_error),
      .umbral_alto    (umbral_alto),
      .umbral_bajo    (umbral_bajo),
      .state          (state),
      .IDLE           (IDLE),
      .active_out     (active_out),
      .error_out      (error_out),
      .cfg_err        (cfg_err)
   );

   always #5 CLK = ~CLK;

   // One record per clock edge: inputs applied before the edge, outputs after
   typedef struct {
      logic       rst;
      logic       ini;
      logic [2:0] ai;
      logic [2:0] bi;
      logic [4:0] emp;
      logic [4:0] ferr;
      int         st;
      int         ha;
      int         lo;
      logic [4:0] err;
      logic       cfg;
   } vec_t;

   vec_t tbl[24];

   // Behavioural model state: mode 0..4 = reset/config/idle/busy/fault
   int         m_mode;
   int         m_hi;
   int         m_lo;
   logic [4:0] m_err;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic check_all(input int st, input int ha, input int lo,
                            input logic [4:0] err, input logic cfg, input string tag);
      check({tag, " state"},      int'(state),       st);
      check({tag, " IDLE"},       int'(IDLE),        (st == 2) ? 1 : 0);
      check({tag, " active_out"}, int'(active_out),  (st == 3) ? 1 : 0);
      check({tag, " umbral_alto"},int'(umbral_alto), ha);
      check({tag, " umbral_bajo"},int'(umbral_bajo), lo);
      check({tag, " error_out"},  int'(error_out),   int'(err));
      check({tag, " cfg_err"},    int'(cfg_err),     int'(cfg));
   endtask

   task automatic drive(input logic r, input logic i, input logic [2:0] a,
                        input logic [2:0] b, input logic [4:0] e, input logic [4:0] f);
      @(negedge CLK);
      reset = r; init = i; umbral_alto_in = a; umbral_bajo_in = b;
      empty = e; fifo_error = f;
      @(posedge CLK);
      #1;
   endtask

   // Reference: one clock edge worth of behaviour, from the rules directly
   task automatic model_edge(input logic r, input logic i, input int a, input int b,
                             input logic [4:0] e, input logic [4:0] f);
      bit bad_cfg;
      bit all_e;
      int nxt;
      bad_cfg = (m_mode == 1) && (b >= a);
      all_e   = (e == 5'b11111);
      if (!r) begin
         m_mode = 0; m_hi = 6; m_lo = 1; m_err = 5'b0;
         return;
      end
      if (m_mode != 0) m_err = m_err | f;
      if (m_mode == 1 && !bad_cfg) begin
         m_hi = a; m_lo = b;
      end
      nxt = m_mode;
      if (m_mode == 0)       nxt = 1;
      else if (m_mode == 4)  nxt = 4;
      else if (f != 0)       nxt = 4;
      else if (m_mode == 1)  nxt = (i || bad_cfg) ? 1 : (all_e ? 2 : 3);
      else if (i)            nxt = 1;
      else                   nxt = all_e ? 2 : 3;
      m_mode = nxt;
   endtask

   initial begin
      // reset / release
      tbl[0]  = '{1'b0,1'b0,3'd6,3'd1,5'b11111,5'b00000, 0,6,1,5'b00000,1'b0};
      tbl[1]  = '{1'b0,1'b0,3'd6,3'd1,5'b11111,5'b00000, 0,6,1,5'b00000,1'b0};
      tbl[2]  = '{1'b1,1'b0,3'd6,3'd1,5'b11111,5'b00000, 1,6,1,5'b00000,1'b0};
      tbl[3]  = '{1'b1,1'b0,3'd6,3'd1,5'b11111,5'b00000, 2,6,1,5'b00000,1'b0};
      // configuration 5/2 then go busy
      tbl[4]  = '{1'b1,1'b1,3'd5,3'd2,5'b11111,5'b00000, 1,6,1,5'b00000,1'b0};
      tbl[5]  = '{1'b1,1'b1,3'd5,3'd2,5'b11111,5'b00000, 1,5,2,5'b00000,1'b0};
      tbl[6]  = '{1'b1,1'b0,3'd5,3'd2,5'b01111,5'b00000, 3,5,2,5'b00000,1'b0};
      // bad configuration after a fresh reset (equal thresholds)
      tbl[7]  = '{1'b0,1'b0,3'd3,3'd3,5'b11111,5'b00000, 0,6,1,5'b00000,1'b0};
      tbl[8]  = '{1'b1,1'b0,3'd3,3'd3,5'b11111,5'b00000, 1,6,1,5'b00000,1'b1};
      tbl[9]  = '{1'b1,1'b0,3'd3,3'd3,5'b11111,5'b00000, 1,6,1,5'b00000,1'b1};
      tbl[10] = '{1'b1,1'b0,3'd3,3'd2,5'b11111,5'b00000, 2,3,2,5'b00000,1'b0};
      // activity toggle
      tbl[11] = '{1'b1,1'b0,3'd3,3'd2,5'b11110,5'b00000, 3,3,2,5'b00000,1'b0};
      tbl[12] = '{1'b1,1'b0,3'd3,3'd2,5'b11111,5'b00000, 2,3,2,5'b00000,1'b0};
      tbl[13] = '{1'b1,1'b0,3'd3,3'd2,5'b11111,5'b00000, 2,3,2,5'b00000,1'b0};
      // error priority over init, sticky accumulation, ERROR is absorbing
      tbl[14] = '{1'b1,1'b0,3'd3,3'd2,5'b01111,5'b00000, 3,3,2,5'b00000,1'b0};
      tbl[15] = '{1'b1,1'b1,3'd3,3'd2,5'b01111,5'b00100, 4,3,2,5'b00100,1'b0};
      tbl[16] = '{1'b1,1'b0,3'd3,3'd2,5'b01111,5'b10000, 4,3,2,5'b10100,1'b0};
      tbl[17] = '{1'b1,1'b1,3'd3,3'd2,5'b11111,5'b00000, 4,3,2,5'b10100,1'b0};
      tbl[18] = '{1'b1,1'b0,3'd3,3'd2,5'b00000,5'b00000, 4,3,2,5'b10100,1'b0};
      // reset mid-error, error ignored in RESET, normal sequence resumes
      tbl[19] = '{1'b0,1'b0,3'd3,3'd2,5'b11111,5'b00000, 0,6,1,5'b00000,1'b0};
      tbl[20] = '{1'b1,1'b0,3'd3,3'd2,5'b11111,5'b00010, 1,6,1,5'b00000,1'b0};
      tbl[21] = '{1'b1,1'b0,3'd3,3'd2,5'b11111,5'b00000, 2,3,2,5'b00000,1'b0};
      // error out of IDLE with init also requested
      tbl[22] = '{1'b1,1'b1,3'd3,3'd2,5'b11111,5'b00001, 4,3,2,5'b00001,1'b0};
      // error captured while in INIT
      tbl[23] = '{1'b0,1'b0,3'd3,3'd2,5'b11111,5'b00000, 0,6,1,5'b00000,1'b0};

      reset = 1'b0; init = 1'b0; umbral_alto_in = 3'd6; umbral_bajo_in = 3'd1;
      empty = 5'b11111; fifo_error = 5'b0;

      for (int k = 0; k < 24; k++) begin
         drive(tbl[k].rst, tbl[k].ini, tbl[k].ai, tbl[k].bi, tbl[k].emp, tbl[k].ferr);
         check_all(tbl[k].st, tbl[k].ha, tbl[k].lo, tbl[k].err, tbl[k].cfg,
                   $sformatf("vec%0d", k));
      end

      // Hand sequence: error while configuring, from reset
      drive(1'b1, 1'b1, 3'd4, 3'd1, 5'b11111, 5'b00000);
      check_all(1, 6, 1, 5'b00000, 1'b0, "seqA init");
      drive(1'b1, 1'b1, 3'd4, 3'd1, 5'b11111, 5'b01000);
      check_all(4, 4, 1, 5'b01000, 1'b0, "seqA err");

      // Randomised phase against the reference model
      m_mode = 4; m_hi = 4; m_lo = 1; m_err = 5'b01000;
      for (int n = 0; n < 600; n++) begin
         logic       r, i;
         logic [2:0] a, b;
         logic [4:0] e, f;
         r = ($urandom_range(0, 19) != 0);
         i = ($urandom_range(0, 5) == 0);
         a = 3'($urandom_range(0, 7));
         b = 3'($urandom_range(0, 7));
         e = ($urandom_range(0, 1) == 0) ? 5'b11111 : 5'($urandom_range(0, 31));
         f = ($urandom_range(0, 14) == 0) ? 5'($urandom_range(1, 31)) : 5'b00000;
         drive(r, i, a, b, e, f);
         model_edge(r, i, int'(a), int'(b), e, f);
         check_all(m_mode, m_hi, m_lo, m_err,
                   (m_mode == 1) && (int'(b) >= int'(a)), $sformatf("rnd%0d", n));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
